// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares four register-file write ports among NUM_REQ requesters
// with round-robin fairness and no duplicate addresses granted in one cycle.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [1:0]            write_en1,
  output logic [1:0]            write_en2,
  output logic [1:0]            write_en3,
  output logic [1:0]            write_en4,
  output logic [AW-1:0]         write_addr1,
  output logic [AW-1:0]         write_addr2,
  output logic [AW-1:0]         write_addr3,
  output logic [AW-1:0]         write_addr4,
  output logic [DW-1:0]         write_data1,
  output logic [DW-1:0]         write_data2,
  output logic [DW-1:0]         write_data3,
  output logic [DW-1:0]         write_data4
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      w_rr_next;
  logic [AW-1:0]      w_req_addr [NUM_REQ];
  logic [DW-1:0]      w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_ready;
  logic [3:0]         w_pen;
  logic [AW-1:0]      w_paddr [4];
  logic [DW-1:0]      w_pdata [4];
  logic [3:0]         r_en;
  logic [AW-1:0]      r_addr [4];
  logic [DW-1:0]      r_data [4];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_addr[g] = req_addr[g*AW +: AW];
    assign w_req_data[g] = req_data[g*DW +: DW];
  end

  // Scan from rr_ptr; k-th grant lands on port k. Data never feeds the grant decision.
  always_comb begin : grant_scan
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_last;
    logic [2:0]    w_cnt;
    logic          w_conflict;
    w_ready    = '0;
    w_pen      = '0;
    for (int p = 0; p < 4; p++) begin
      w_paddr[p] = '0;
      w_pdata[p] = '0;
    end
    w_sum      = '0;
    w_idx      = '0;
    w_last     = r_rr_ptr;
    w_cnt      = '0;
    w_conflict = 1'b0;
    if (rst_n && !wb_hold) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        w_sum = {1'b0, r_rr_ptr} + (PW+1)'(j);
        if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
        w_idx = w_sum[PW-1:0];
        if (req_valid[w_idx] && (w_cnt < 3'd4)) begin
          w_conflict = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if ((3'(k) < w_cnt) && (w_paddr[k] == w_req_addr[w_idx])) w_conflict = 1'b1;
          end
          if (!w_conflict) begin
            w_ready[w_idx]      = 1'b1;
            w_pen[w_cnt[1:0]]   = 1'b1;
            w_paddr[w_cnt[1:0]] = w_req_addr[w_idx];
            w_pdata[w_cnt[1:0]] = w_req_data[w_idx];
            w_cnt               = w_cnt + 3'd1;
            w_last              = w_idx;
          end
        end
      end
    end
    w_sum = {1'b0, w_last} + (PW+1)'(1);
    if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = '0;
    w_rr_next = (w_cnt != 3'd0) ? w_sum[PW-1:0] : r_rr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_en     <= '0;
      for (int p = 0; p < 4; p++) begin
        r_addr[p] <= '0;
        r_data[p] <= '0;
      end
    end else begin
      r_rr_ptr <= w_rr_next;
      r_en     <= w_pen;
      for (int p = 0; p < 4; p++) begin
        r_addr[p] <= w_paddr[p];
        r_data[p] <= w_pdata[p];
      end
    end
  end

  assign req_ready   = w_ready;
  assign write_en1   = {1'b0, r_en[0]};
  assign write_en2   = {1'b0, r_en[1]};
  assign write_en3   = {1'b0, r_en[2]};
  assign write_en4   = {1'b0, r_en[3]};
  assign write_addr1 = r_addr[0];
  assign write_addr2 = r_addr[1];
  assign write_addr3 = r_addr[2];
  assign write_addr4 = r_addr[3];
  assign write_data1 = r_data[0];
  assign write_data2 = r_data[1];
  assign write_data3 = r_data[2];
  assign write_data4 = r_data[3];

endmodule
